// File: rtl/mdu_div_unit.sv
// Multi-cycle RV32M divider: restoring radix-2, one quotient bit per cycle.
// Stalls the pipeline through busy_o and releases it with the valid_o pulse.
module mdu_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             remop_q, remop_d;

    logic             sgn, a_neg, b_neg;
    logic             div_zero, ovf, special;
    logic [WIDTH-1:0] a_abs, b_abs, spec_res;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx, fin;

    // Operand preparation at the accepting edge
    assign sgn      = ~op_i[0];
    assign a_neg    = sgn & a_i[WIDTH-1];
    assign b_neg    = sgn & b_i[WIDTH-1];
    assign a_abs    = a_neg ? -a_i : a_i;
    assign b_abs    = b_neg ? -b_i : b_i;
    assign div_zero = (b_i == '0);
    assign ovf      = sgn & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_i);
    assign special  = div_zero | ovf;
    assign spec_res = div_zero ? (op_i[1] ? a_i : '1)
                               : (op_i[1] ? '0 : a_i);

    // Dividend bits shift from quo_q into the partial remainder
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, div_q});
    assign rem_nx  = ge ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], ge};
    assign fin     = remop_q ? (rneg_q ? -rem_nx : rem_nx)
                             : (qneg_q ? -quo_nx : quo_nx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        unique case (state_q)
            IDLE:    busy_o = start_i & rst_n;
            CALC:    busy_o = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        res_d   = res_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        remop_d = remop_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d   = '0;
                    quo_d   = a_abs;
                    div_d   = b_abs;
                    cnt_d   = CNT_W'(WIDTH-1);
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    remop_d = op_i[1];
                    if (special) res_d = spec_res;
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) res_d = fin;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            res_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            remop_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            res_q   <= res_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            remop_q <= remop_d;
        end
    end

    assign result_o = res_q;

endmodule

// File: tb/tb_mdu_div_unit.sv
// Randomized bench for mdu_div_unit against a plain-arithmetic
// RISC-V division model, including latency and stall-signal checks.
module tb_mdu_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_exp = '0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    mdu_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [31:0] a, b);
        return (b == 0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V semantics: truncating division, remainder follows dividend
    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a, b);
        longint sa, sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == MIN && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : MIN;
        sa = op[0] ? longint'(a) : longint'($signed(a));
        sb = op[0] ? longint'(b) : longint'($signed(b));
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, b);
        logic [31:0] er;
        int lat;
        bit seen;
        er  = model(op, a, b);
        lat = is_special(op, a, b) ? 1 : 33;
        @(negedge clk);
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        #1;
        chk("busy_issue", busy_o, 1);
        chk("valid_issue", valid_o, 0);
        seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            op_i = 2'($urandom);
            a_i = $urandom;
            b_i = $urandom;
            #1;
            if (valid_o) begin
                seen = 1;
                chk("latency", k, lat);
                chk("busy_done", busy_o, 0);
                chk("result", result_o, er);
            end else begin
                chk("busy_calc", busy_o, 1);
            end
        end
        if (!seen) chk("timeout", 0, 1);
        last_exp = er;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("valid_idle", valid_o, 0);
        chk("busy_idle", busy_o, 0);
        chk("result_hold", result_o, last_exp);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        start_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'd100;
        b_i = 32'd7;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_busy", busy_o, 0);

        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE);
        idle_cycle();
        run_op(2'b01, 32'h1234, 32'd0);
        run_op(2'b10, 32'h1234, 32'd0);
        run_op(2'b00, MIN, 32'hFFFF_FFFF);
        run_op(2'b10, MIN, 32'hFFFF_FFFF);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        idle_cycle();

        // Abort a division mid-flight
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'hDEAD_BEEF;
        b_i = 32'd5;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_result", result_o, 0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("abort_novalid", valid_o, 0);
        end
        run_op(2'b01, 32'd9, 32'd3);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = MIN; b = 32'hFFFF_FFFF; end
                3: b = $urandom >> $urandom_range(0, 31);
                4: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, a, b);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
